pmu_wake_ctrl: RTL and testbench
================================

// Module: pmu_wake_ctrl
// PURPOSE
//  Power-management sequencer on the consumer side of the per-interrupt wic cells.
//  - Accepts the CPU low-power request and gates the CPU clock.
//  - Watches the wic int_pending/wic_awake_en vectors while asleep.
//  - Restores the clock, signals wakeup to the CPU, then pulses pending_clr back to the winning wic cell.
//  - Always-on domain, clocked by wic_clk.
// PARAMETERS
//  INT_NUM   32  number of wic cells / interrupt sources
//  ID_W      5   width of wake_src_id; must satisfy 2**ID_W >= INT_NUM
//  ENT_DLY   4   cycles in ENTER before cpu_clk_en drops (pipeline drain); 1..15
//  WAKE_DLY  4   cycles in RESTORE after cpu_clk_en rises, before wakeup is signalled; 1..15
//  TMO_CYC   1024 sleep timeout in cycles; used only with PMU_WAKE_TMO_EN; 1..65535
// PORTS
//  wic_clk         in   1        always-on clock, also clocks the wic cells
//  pad_cpu_rst_b   in   1        asynchronous active-low reset
//  cpu_pad_lpmd_b  in   2        CPU low-power request: 2'b11 = run, any other value = sleep request
//  int_pending     in   INT_NUM  per-source pending from wic cells
//  wic_awake_en    in   INT_NUM  per-source wake enable from wic cells
//  cpu_clk_en      out  1        CPU clock-gate enable
//  pmu_cpu_wakeup  out  1        level wakeup indication to CPU
//  pending_clr     out  INT_NUM  one-cycle one-hot clear to the winning wic cell
//  wake_src_vld    out  1        wake_src_id holds a captured source
//  wake_src_id     out  ID_W     index of the captured wake source
//  wake_tmo        out  1        timeout wake flag; exists only with PMU_WAKE_TMO_EN
// BEHAVIOUR
//  Reset values: state = RUN, cpu_clk_en = 1, and all other outputs 0.
//  Reset mid-operation returns to RUN immediately and forces cpu_clk_en = 1.
//  All outputs are registered.
//  wake = |(int_pending & wic_awake_en), evaluated combinationally each cycle.
//  Winning source = lowest index set in (int_pending & wic_awake_en).
//  The winner is captured into wake_src_id/wake_src_vld on the cycle that wake is accepted.
//  FSM:
//  - RUN: when cpu_pad_lpmd_b != 2'b11, load the counter with ENT_DLY and go to ENTER.
//  - ENTER: counter decrements each cycle.
//    - Request withdrawn (lpmd_b == 2'b11): go to RUN, clock never gated.
//    - Else if wake: capture the winner and go to EXIT; clock never gated.
//    - Else when the counter reaches 0: cpu_clk_en <= 0 and go to SLEEP.
//    - Withdrawal has priority over wake.
//  - SLEEP: cpu_clk_en = 0.
//    - On wake: capture the winner, cpu_clk_en <= 1, load the counter with WAKE_DLY, go to RESTORE.
//    - Wake is sampled every cycle; the lpmd_b value is ignored because the CPU is gated.
//  - RESTORE: counter decrements each cycle; at 0, pmu_cpu_wakeup <= 1 and go to EXIT.
//    - Pending deassertion during RESTORE does not abort; the captured id is kept.
//  - EXIT: pmu_cpu_wakeup held at 1 until cpu_pad_lpmd_b == 2'b11.
//    - On that cycle: pmu_cpu_wakeup <= 0, pending_clr <= onehot(wake_src_id) for exactly 1 cycle, wake_src_vld <= 0, go to RUN.
//    - If the sleep request is still asserted after the clear cycle, RUN re-enters ENTER on the next cycle.
//  Latency: wake asserted in SLEEP at cycle N gives cpu_clk_en = 1 at N+1 and pmu_cpu_wakeup = 1 at N+1+WAKE_DLY.
//  Counters are 4 bits and saturate at 0; no wrap-around.
//  Simultaneous pending sources: only the winner is cleared; the others remain pending and are serviced by the CPU normally.
//  Mask all zero: SLEEP is held indefinitely, unless PMU_WAKE_TMO_EN is compiled in.
//  pending_clr is never asserted outside the EXIT->RUN transition.
// CONFIGURATION
//  PMU_WAKE_TMO_EN defined:
//  - A 16-bit counter loads TMO_CYC on entry to SLEEP and decrements each SLEEP cycle.
//  - At 0 without wake: wake_tmo <= 1, wake_src_vld stays 0, and the normal RESTORE/EXIT sequence runs.
//  - For a timeout wake, pending_clr stays all-zero on exit.
//  - wake_tmo clears on the EXIT->RUN transition.
//  - A real wake in the same cycle as the timeout wins: wake_tmo stays 0.
//  PMU_WAKE_TMO_EN undefined: no wake_tmo port, no timeout counter; SLEEP is left only via wake.
// TESTING
//  1 Basic: lpmd_b=00, awake_en[3]=1, pend[3] rises 10 cycles after gating -> clk_en 1 next cycle, wakeup after 4, id=3; lpmd_b=11 -> pending_clr=32'h8 for 1 cycle.
//  2 Priority: pend[7] and pend[2] both rise in the same SLEEP cycle, both enabled -> id=2, pending_clr=32'h4 only.
//  3 Masked: pend[5]=1 with awake_en[5]=0 while asleep -> clk_en stays 0; set awake_en[5] -> wake, id=5.
//  4 Abort: wake during ENTER cycle 2 -> clk_en never drops, EXIT directly; separately lpmd_b back to 11 in ENTER -> RUN, no pending_clr.
//  5 Reset: assert pad_cpu_rst_b in SLEEP and in RESTORE -> clk_en=1 and all other outputs 0 asynchronously, state RUN.
//  6 Timeout (PMU_WAKE_TMO_EN, TMO_CYC=16): sleep with mask 0 -> wake_tmo=1 after 16 cycles, wakeup after +1+4 cycles, pending_clr stays 0.

Source files
------------

// File: rtl/pmu_wake_ctrl.sv
// Always-on sleep/wake sequencer between the CPU low-power request and the per-interrupt wic cells.
// Optional sleep timeout is compiled in with `define PMU_WAKE_TMO_EN.
module pmu_wake_ctrl #(
   parameter int INT_NUM  = 32,
   parameter int ID_W     = 5,
   parameter int ENT_DLY  = 4,
   parameter int WAKE_DLY = 4,
   parameter int TMO_CYC  = 1024
) (
   input  logic               wic_clk,
   input  logic               pad_cpu_rst_b,
   input  logic [1:0]         cpu_pad_lpmd_b,
   input  logic [INT_NUM-1:0] int_pending,
   input  logic [INT_NUM-1:0] wic_awake_en,
   output logic               cpu_clk_en,
   output logic               pmu_cpu_wakeup,
   output logic [INT_NUM-1:0] pending_clr,
   output logic               wake_src_vld,
   output logic [ID_W-1:0]    wake_src_id
`ifdef PMU_WAKE_TMO_EN
   ,
   output logic               wake_tmo
`endif
);

   // state   | meaning
   // RUN     | CPU running, clock on, waiting for a sleep request
   // ENTER   | pipeline drain, ENT_DLY cycles before the clock is gated
   // SLEEP   | CPU clock gated, watching the wake vector
   // RESTORE | clock back on, WAKE_DLY cycles before wakeup is signalled
   // EXIT    | wakeup held until the CPU withdraws its request
   typedef enum logic [2:0] {ST_RUN, ST_ENTER, ST_SLEEP, ST_RESTORE, ST_EXIT} state_t;

   if (ENT_DLY < 1 || ENT_DLY > 15 || WAKE_DLY < 1 || WAKE_DLY > 15 ||
       TMO_CYC < 1 || TMO_CYC > 65535 || (2**ID_W) < INT_NUM) begin : g_cfg_err
      $error("pmu_wake_ctrl: illegal parameter combination");
   end

   state_t             state;
   logic [3:0]         dly_cnt;
   logic [INT_NUM-1:0] wake_vec;
   logic [INT_NUM-1:0] clr_vec;
   logic [ID_W-1:0]    win_id;
   logic               wake;
   logic               run_req;
`ifdef PMU_WAKE_TMO_EN
   logic [15:0]        tmo_cnt;
`endif

   assign wake_vec = int_pending & wic_awake_en;
   assign wake     = |wake_vec;
   assign run_req  = (cpu_pad_lpmd_b == 2'b11);

   always_comb begin
      win_id = '0;
      for (int i = INT_NUM - 1; i >= 0; i--) begin
         if (wake_vec[i]) win_id = ID_W'(i);
      end
   end

   // A timeout wake leaves wake_src_vld low, so nothing is cleared on exit.
   always_comb begin
      clr_vec = '0;
      for (int i = 0; i < INT_NUM; i++) begin
         clr_vec[i] = wake_src_vld && (wake_src_id == ID_W'(i));
      end
   end

   always_ff @(posedge wic_clk or negedge pad_cpu_rst_b) begin
      if (!pad_cpu_rst_b) begin
         state          <= ST_RUN;
         dly_cnt        <= '0;
         cpu_clk_en     <= 1'b1;
         pmu_cpu_wakeup <= 1'b0;
         pending_clr    <= '0;
         wake_src_vld   <= 1'b0;
         wake_src_id    <= '0;
`ifdef PMU_WAKE_TMO_EN
         tmo_cnt        <= '0;
         wake_tmo       <= 1'b0;
`endif
      end else begin
         pending_clr <= '0;
         case (state)
            ST_RUN: begin
               if (!run_req) begin
                  dly_cnt <= 4'(ENT_DLY);
                  state   <= ST_ENTER;
               end
            end
            ST_ENTER: begin
               if (run_req) begin
                  dly_cnt <= '0;
                  state   <= ST_RUN;
               end else if (wake) begin
                  wake_src_vld   <= 1'b1;
                  wake_src_id    <= win_id;
                  pmu_cpu_wakeup <= 1'b1;
                  dly_cnt        <= '0;
                  state          <= ST_EXIT;
               end else if (dly_cnt <= 4'd1) begin
                  cpu_clk_en <= 1'b0;
                  dly_cnt    <= '0;
`ifdef PMU_WAKE_TMO_EN
                  tmo_cnt    <= 16'(TMO_CYC);
`endif
                  state      <= ST_SLEEP;
               end else begin
                  dly_cnt <= dly_cnt - 4'd1;
               end
            end
            ST_SLEEP: begin
               if (wake) begin
                  wake_src_vld <= 1'b1;
                  wake_src_id  <= win_id;
                  cpu_clk_en   <= 1'b1;
                  dly_cnt      <= 4'(WAKE_DLY);
                  state        <= ST_RESTORE;
               end
`ifdef PMU_WAKE_TMO_EN
               else if (tmo_cnt <= 16'd1) begin
                  wake_tmo   <= 1'b1;
                  tmo_cnt    <= '0;
                  cpu_clk_en <= 1'b1;
                  dly_cnt    <= 4'(WAKE_DLY);
                  state      <= ST_RESTORE;
               end else begin
                  tmo_cnt <= tmo_cnt - 16'd1;
               end
`endif
            end
            ST_RESTORE: begin
               if (dly_cnt <= 4'd1) begin
                  dly_cnt        <= '0;
                  pmu_cpu_wakeup <= 1'b1;
                  state          <= ST_EXIT;
               end else begin
                  dly_cnt <= dly_cnt - 4'd1;
               end
            end
            ST_EXIT: begin
               if (run_req) begin
                  pmu_cpu_wakeup <= 1'b0;
                  pending_clr    <= clr_vec;
                  wake_src_vld   <= 1'b0;
`ifdef PMU_WAKE_TMO_EN
                  wake_tmo       <= 1'b0;
`endif
                  state          <= ST_RUN;
               end
            end
            default: begin
               cpu_clk_en <= 1'b1;
               state      <= ST_RUN;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_pmu_wake_ctrl.sv
// Scoreboard bench for pmu_wake_ctrl: expected pending_clr values are queued when a wake is driven.
module tb_pmu_wake_ctrl;
   localparam int INT_NUM  = 32;
   localparam int ID_W     = 5;
   localparam int ENT_DLY  = 4;
   localparam int WAKE_DLY = 4;
   localparam int TMO_CYC  = 16;

   logic               wic_clk = 1'b0;
   logic               pad_cpu_rst_b = 1'b1;
   logic [1:0]         cpu_pad_lpmd_b = 2'b11;
   logic [INT_NUM-1:0] int_pending = '0;
   logic [INT_NUM-1:0] wic_awake_en = '0;
   logic               cpu_clk_en;
   logic               pmu_cpu_wakeup;
   logic [INT_NUM-1:0] pending_clr;
   logic               wake_src_vld;
   logic [ID_W-1:0]    wake_src_id;
`ifdef PMU_WAKE_TMO_EN
   logic               wake_tmo;
`endif

   int errors = 0;
   int checks = 0;
   logic [INT_NUM-1:0] exp_q[$];

   pmu_wake_ctrl #(
      .INT_NUM(INT_NUM), .ID_W(ID_W), .ENT_DLY(ENT_DLY), .WAKE_DLY(WAKE_DLY), .TMO_CYC(TMO_CYC)
   ) dut (
      .wic_clk(wic_clk),
      .pad_cpu_rst_b(pad_cpu_rst_b),
      .cpu_pad_lpmd_b(cpu_pad_lpmd_b),
      .int_pending(int_pending),
      .wic_awake_en(wic_awake_en),
      .cpu_clk_en(cpu_clk_en),
      .pmu_cpu_wakeup(pmu_cpu_wakeup),
      .pending_clr(pending_clr),
      .wake_src_vld(wake_src_vld),
      .wake_src_id(wake_src_id)
`ifdef PMU_WAKE_TMO_EN
      ,
      .wake_tmo(wake_tmo)
`endif
   );

   always #5 wic_clk = ~wic_clk;

   // Every nonzero pending_clr must match the next queued expectation.
   always @(negedge wic_clk) begin
      if (pad_cpu_rst_b === 1'b1 && pending_clr !== '0) begin
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_clr: got %h, required none", pending_clr);
         end else begin
            logic [INT_NUM-1:0] e;
            e = exp_q.pop_front();
            if (pending_clr !== e) begin
               errors++;
               $display("FAIL clr_value: got %h, required %h", pending_clr, e);
            end
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   task automatic step(int n = 1);
      repeat (n) begin
         @(posedge wic_clk);
         #1;
      end
   endtask

   task automatic wait_gated(output int n);
      n = 0;
      while (cpu_clk_en !== 1'b0 && n < 40) begin
         step();
         n++;
      end
   endtask

   task automatic wait_wakeup(output int n);
      n = 0;
      while (pmu_cpu_wakeup !== 1'b1 && n < 40) begin
         step();
         n++;
      end
   endtask

   task automatic test_reset();
      #2 pad_cpu_rst_b = 1'b0;
      #1;
      checks++;
      if (cpu_clk_en !== 1'b1 || pmu_cpu_wakeup !== 1'b0 || pending_clr !== '0 ||
          wake_src_vld !== 1'b0 || wake_src_id !== '0) begin
         errors++;
         $display("FAIL reset_values: got clk_en=%b wakeup=%b clr=%h vld=%b id=%0d, required 1 0 0 0 0",
                  cpu_clk_en, pmu_cpu_wakeup, pending_clr, wake_src_vld, wake_src_id);
      end
`ifdef PMU_WAKE_TMO_EN
      checks++;
      if (wake_tmo !== 1'b0) begin
         errors++;
         $display("FAIL reset_tmo: got %b, required 0", wake_tmo);
      end
`endif
      step(2);
      #2 pad_cpu_rst_b = 1'b1;
      step(2);
   endtask

   task automatic test_basic();
      int n;
      wic_awake_en = 32'h8;
      cpu_pad_lpmd_b = 2'b00;
      wait_gated(n);
      checks++;
      if (n != ENT_DLY + 1) begin
         errors++;
         $display("FAIL basic_gate_lat: got %0d, required %0d", n, ENT_DLY + 1);
      end
      step(9);
      int_pending[3] = 1'b1;
      exp_q.push_back(32'h8);
      step();
      checks++;
      if (cpu_clk_en !== 1'b1 || pmu_cpu_wakeup !== 1'b0 || wake_src_vld !== 1'b1 || wake_src_id !== 5'd3) begin
         errors++;
         $display("FAIL basic_wake: got clk_en=%b wakeup=%b vld=%b id=%0d, required 1 0 1 3",
                  cpu_clk_en, pmu_cpu_wakeup, wake_src_vld, wake_src_id);
      end
      wait_wakeup(n);
      checks++;
      if (n != WAKE_DLY) begin
         errors++;
         $display("FAIL basic_wakeup_lat: got %0d, required %0d", n, WAKE_DLY);
      end
      cpu_pad_lpmd_b = 2'b11;
      step();
      checks++;
      if (pmu_cpu_wakeup !== 1'b0 || wake_src_vld !== 1'b0 || pending_clr !== 32'h8) begin
         errors++;
         $display("FAIL basic_exit: got wakeup=%b vld=%b clr=%h, required 0 0 00000008",
                  pmu_cpu_wakeup, wake_src_vld, pending_clr);
      end
      int_pending = '0;
      step();
      checks++;
      if (pending_clr !== '0) begin
         errors++;
         $display("FAIL basic_clr_width: got %h, required 0", pending_clr);
      end
   endtask

   task automatic test_priority();
      int n;
      wic_awake_en = 32'h84;
      cpu_pad_lpmd_b = 2'b00;
      wait_gated(n);
      step(3);
      int_pending = 32'h84;
      exp_q.push_back(32'h4);
      step();
      checks++;
      if (wake_src_vld !== 1'b1 || wake_src_id !== 5'd2) begin
         errors++;
         $display("FAIL prio_id: got vld=%b id=%0d, required 1 2", wake_src_vld, wake_src_id);
      end
      int_pending = 32'h80;
      wait_wakeup(n);
      cpu_pad_lpmd_b = 2'b11;
      step(2);
      int_pending = '0;
      wic_awake_en = '0;
      step();
   endtask

   task automatic test_masked();
      int n;
      logic stayed;
      wic_awake_en = '0;
      int_pending = 32'h20;
      cpu_pad_lpmd_b = 2'b00;
      wait_gated(n);
      checks++;
      if (n != ENT_DLY + 1) begin
         errors++;
         $display("FAIL mask_gate_lat: got %0d, required %0d", n, ENT_DLY + 1);
      end
      stayed = 1'b1;
      for (int i = 0; i < 8; i++) begin
         step();
         if (cpu_clk_en !== 1'b0) stayed = 1'b0;
      end
      checks++;
      if (!stayed) begin
         errors++;
         $display("FAIL mask_hold: got clk_en rising while masked, required 0");
      end
      wic_awake_en = 32'h20;
      exp_q.push_back(32'h20);
      step();
      checks++;
      if (cpu_clk_en !== 1'b1 || wake_src_id !== 5'd5) begin
         errors++;
         $display("FAIL mask_wake: got clk_en=%b id=%0d, required 1 5", cpu_clk_en, wake_src_id);
      end
      wait_wakeup(n);
      cpu_pad_lpmd_b = 2'b11;
      step();
      int_pending = '0;
      wic_awake_en = '0;
      step();
   endtask

   task automatic test_abort();
      logic never_gated;
      wic_awake_en = 32'h2;
      int_pending = '0;
      cpu_pad_lpmd_b = 2'b00;
      never_gated = 1'b1;
      for (int i = 0; i < 2; i++) begin
         step();
         if (cpu_clk_en !== 1'b1) never_gated = 1'b0;
      end
      int_pending[1] = 1'b1;
      exp_q.push_back(32'h2);
      step();
      if (cpu_clk_en !== 1'b1) never_gated = 1'b0;
      checks++;
      if (!never_gated || pmu_cpu_wakeup !== 1'b1 || wake_src_vld !== 1'b1 || wake_src_id !== 5'd1) begin
         errors++;
         $display("FAIL abort_wake: got gated=%b wakeup=%b vld=%b id=%0d, required 0 1 1 1",
                  !never_gated, pmu_cpu_wakeup, wake_src_vld, wake_src_id);
      end
      cpu_pad_lpmd_b = 2'b11;
      step();
      int_pending = '0;
      wic_awake_en = '0;
      step();
      cpu_pad_lpmd_b = 2'b00;
      step(2);
      cpu_pad_lpmd_b = 2'b11;
      step();
      never_gated = (cpu_clk_en === 1'b1);
      for (int i = 0; i < ENT_DLY + 2; i++) begin
         step();
         if (cpu_clk_en !== 1'b1 || pmu_cpu_wakeup !== 1'b0) never_gated = 1'b0;
      end
      checks++;
      if (!never_gated) begin
         errors++;
         $display("FAIL abort_withdraw: got clk_en=%b wakeup=%b after withdrawal, required 1 0",
                  cpu_clk_en, pmu_cpu_wakeup);
      end
   endtask

   task automatic test_reset_midop();
      int n;
      wic_awake_en = '0;
      int_pending = '0;
      cpu_pad_lpmd_b = 2'b00;
      wait_gated(n);
      step(2);
      #2 pad_cpu_rst_b = 1'b0;
      #1;
      checks++;
      if (cpu_clk_en !== 1'b1 || pmu_cpu_wakeup !== 1'b0 || wake_src_vld !== 1'b0 || pending_clr !== '0) begin
         errors++;
         $display("FAIL rst_sleep: got clk_en=%b wakeup=%b vld=%b clr=%h, required 1 0 0 0",
                  cpu_clk_en, pmu_cpu_wakeup, wake_src_vld, pending_clr);
      end
      cpu_pad_lpmd_b = 2'b11;
      step(2);
      #2 pad_cpu_rst_b = 1'b1;
      step(2);
      wic_awake_en = 32'h10;
      cpu_pad_lpmd_b = 2'b00;
      wait_gated(n);
      int_pending = 32'h10;
      step(2);
      #2 pad_cpu_rst_b = 1'b0;
      #1;
      checks++;
      if (cpu_clk_en !== 1'b1 || pmu_cpu_wakeup !== 1'b0 || wake_src_vld !== 1'b0 || wake_src_id !== '0) begin
         errors++;
         $display("FAIL rst_restore: got clk_en=%b wakeup=%b vld=%b id=%0d, required 1 0 0 0",
                  cpu_clk_en, pmu_cpu_wakeup, wake_src_vld, wake_src_id);
      end
      int_pending = '0;
      wic_awake_en = '0;
      cpu_pad_lpmd_b = 2'b11;
      step();
      #2 pad_cpu_rst_b = 1'b1;
      step(WAKE_DLY + 3);
      checks++;
      if (pmu_cpu_wakeup !== 1'b0 || cpu_clk_en !== 1'b1) begin
         errors++;
         $display("FAIL rst_resume: got wakeup=%b clk_en=%b, required 0 1", pmu_cpu_wakeup, cpu_clk_en);
      end
   endtask

   task automatic test_back_to_back();
      int n;
      wic_awake_en = 32'h8000_0001;
      cpu_pad_lpmd_b = 2'b00;
      wait_gated(n);
      int_pending = 32'h8000_0000;
      exp_q.push_back(32'h8000_0000);
      step();
      checks++;
      if (wake_src_id !== 5'd31) begin
         errors++;
         $display("FAIL b2b_id31: got %0d, required 31", wake_src_id);
      end
      wait_wakeup(n);
      cpu_pad_lpmd_b = 2'b11;
      step();
      int_pending = '0;
      cpu_pad_lpmd_b = 2'b00;
      wait_gated(n);
      checks++;
      if (n != ENT_DLY + 1) begin
         errors++;
         $display("FAIL b2b_reenter: got %0d, required %0d", n, ENT_DLY + 1);
      end
      int_pending = 32'h1;
      exp_q.push_back(32'h1);
      step();
      checks++;
      if (wake_src_id !== 5'd0 || wake_src_vld !== 1'b1) begin
         errors++;
         $display("FAIL b2b_id0: got vld=%b id=%0d, required 1 0", wake_src_vld, wake_src_id);
      end
      wait_wakeup(n);
      checks++;
      if (n != WAKE_DLY) begin
         errors++;
         $display("FAIL b2b_wakeup_lat: got %0d, required %0d", n, WAKE_DLY);
      end
      cpu_pad_lpmd_b = 2'b11;
      step();
      int_pending = '0;
      wic_awake_en = '0;
      step();
   endtask

`ifdef PMU_WAKE_TMO_EN
   task automatic test_timeout();
      int n;
      wic_awake_en = '0;
      int_pending = '0;
      cpu_pad_lpmd_b = 2'b00;
      wait_gated(n);
      n = 0;
      while (wake_tmo !== 1'b1 && n < 100) begin
         step();
         n++;
      end
      checks++;
      if (n != TMO_CYC || cpu_clk_en !== 1'b1 || wake_src_vld !== 1'b0) begin
         errors++;
         $display("FAIL tmo_lat: got %0d clk_en=%b vld=%b, required %0d 1 0", n, cpu_clk_en, wake_src_vld, TMO_CYC);
      end
      wait_wakeup(n);
      checks++;
      if (n != WAKE_DLY) begin
         errors++;
         $display("FAIL tmo_wakeup_lat: got %0d, required %0d", n, WAKE_DLY);
      end
      cpu_pad_lpmd_b = 2'b11;
      step();
      checks++;
      if (wake_tmo !== 1'b0 || pmu_cpu_wakeup !== 1'b0) begin
         errors++;
         $display("FAIL tmo_exit: got tmo=%b wakeup=%b, required 0 0", wake_tmo, pmu_cpu_wakeup);
      end
      step();
   endtask
`endif

   initial begin
      test_reset();
      test_basic();
      test_priority();
      test_masked();
      test_abort();
      test_reset_midop();
      test_back_to_back();
`ifdef PMU_WAKE_TMO_EN
      test_timeout();
`endif
      step(3);
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL scoreboard_drain: got %0d outstanding, required 0", exp_q.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
